// File: rtl/vehicle_mode_core_if.sv
// UART link between vehicle_mode_core (master) and uart_top (slave).
// The link carries command frames out and detector bytes in.
interface vehicle_mode_core_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (output tx_data, tx_valid, input tx_ready, rx_data, rx_valid);
  modport slave  (input tx_data, tx_valid, output tx_ready, rx_data, rx_valid);
endinterface

// File: rtl/vehicle_mode_core.sv
// Vehicle top-level core: power/mode-switch FSM with a drain window on mode change,
// paced command-frame TX and stale-supervised detector RX.
module vehicle_mode_core #(
  parameter  int NUM_MODES   = 3,
  parameter  int STATE_W     = 2,
  parameter  int MOVE_W      = 4,
  parameter  int SW_HOLD     = 4,
  parameter  int TX_PERIOD   = 10000,
  parameter  int STALE_LIMIT = 1000000,
  localparam int MODE_W      = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1
) (
  input  logic                          sys_clk,
  input  logic                          rst,
  input  logic                          power_req,
  input  logic [MODE_W-1:0]             mode_req,
  input  logic [NUM_MODES*STATE_W-1:0]  mode_next_state,
  input  logic [NUM_MODES*MOVE_W-1:0]   mode_next_move,
  output logic                          power,
  output logic [MODE_W-1:0]             active_mode,
  output logic [STATE_W-1:0]            state,
  output logic [MOVE_W-1:0]             moving_state,
  output logic [2**STATE_W-1:0]         state_light,
  output logic                          switching,
  output logic [3:0]                    detector,
  output logic                          detector_stale,
  vehicle_mode_core_if.master           link
);
  localparam int LIGHT_W = 2**STATE_W;
  localparam int HOLD_W  = $clog2(SW_HOLD + 1);
  localparam int PER_W   = $clog2(TX_PERIOD);
  localparam int STALE_W = $clog2(STALE_LIMIT + 1);

  typedef enum logic [1:0] {OFF, RUN, DRAIN} fsm_t;

  fsm_t               fsm_q, fsm_d;
  logic [MODE_W-1:0]  mode_d, mode_sel;
  logic [STATE_W-1:0] state_d;
  logic [MOVE_W-1:0]  move_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               mode_ok;

  // Table padded to a power of two so any index width is safe.
  logic [STATE_W-1:0] st_tbl [2**MODE_W];
  logic [MOVE_W-1:0]  mv_tbl [2**MODE_W];

  for (genvar i = 0; i < 2**MODE_W; i++) begin : g_tbl
    if (i < NUM_MODES) begin : g_mode
      assign st_tbl[i] = mode_next_state[i*STATE_W +: STATE_W];
      assign mv_tbl[i] = mode_next_move[i*MOVE_W +: MOVE_W];
    end else begin : g_pad
      assign st_tbl[i] = '0;
      assign mv_tbl[i] = '0;
    end
  end

  assign mode_ok  = int'(mode_req) < NUM_MODES;
  assign mode_sel = mode_ok ? mode_req : active_mode;

  always_comb begin
    fsm_d   = fsm_q;
    mode_d  = active_mode;
    state_d = '0;
    move_d  = '0;
    hold_d  = hold_q;
    unique case (fsm_q)
      OFF: begin
        mode_d = mode_sel;
        if (power_req) fsm_d = RUN;
      end
      RUN: begin
        if (!power_req) begin
          fsm_d = OFF;
        end else if (mode_ok && mode_req != active_mode) begin
          fsm_d  = DRAIN;
          hold_d = HOLD_W'(SW_HOLD - 1);
        end else begin
          state_d = st_tbl[active_mode];
          move_d  = mv_tbl[active_mode];
        end
      end
      DRAIN: begin
        if (!power_req) begin
          fsm_d = OFF;
        end else if (hold_q == '0) begin
          // Load the new mode's outputs on the exit edge so zeros last exactly SW_HOLD cycles.
          fsm_d   = RUN;
          mode_d  = mode_sel;
          state_d = st_tbl[mode_sel];
          move_d  = mv_tbl[mode_sel];
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: fsm_d = OFF;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      fsm_q        <= OFF;
      active_mode  <= '0;
      state        <= '0;
      moving_state <= '0;
      state_light  <= '0;
      hold_q       <= '0;
    end else begin
      fsm_q        <= fsm_d;
      active_mode  <= mode_d;
      state        <= state_d;
      moving_state <= move_d;
      state_light  <= (fsm_d != OFF) ? (LIGHT_W'(1) << state_d) : '0;
      hold_q       <= hold_d;
    end
  end

  assign power     = (fsm_q != OFF);
  assign switching = (fsm_q == DRAIN);

  logic [PER_W-1:0] per_q;
  logic             wrap;
  logic [1:0]       mode_lo;
  logic [7:0]       frame;

  if (MODE_W >= 2) begin : g_mlo
    assign mode_lo = active_mode[1:0];
  end else begin : g_mlo1
    assign mode_lo = {1'b0, active_mode};
  end

  assign wrap  = (per_q == PER_W'(TX_PERIOD - 1));
  assign frame = {2'b10, mode_lo, 4'(moving_state)};

  // A wrap that finds a frame still pending is simply dropped.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      per_q         <= '0;
      link.tx_valid <= 1'b0;
      link.tx_data  <= '0;
    end else begin
      per_q <= wrap ? '0 : per_q + 1'b1;
      if (link.tx_valid) begin
        if (link.tx_ready) link.tx_valid <= 1'b0;
      end else if (wrap) begin
        link.tx_valid <= 1'b1;
        link.tx_data  <= frame;
      end
    end
  end

  logic [STALE_W-1:0] stale_q;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      stale_q        <= '0;
      detector       <= 4'hF;
      detector_stale <= 1'b1;
    end else if (link.rx_valid) begin
      stale_q        <= '0;
      detector       <= link.rx_data[3:0];
      detector_stale <= 1'b0;
    end else if (stale_q != STALE_W'(STALE_LIMIT)) begin
      stale_q <= stale_q + 1'b1;
      if (stale_q == STALE_W'(STALE_LIMIT - 1)) begin
        detector_stale <= 1'b1;
        detector       <= 4'hF;
      end
    end
  end
endmodule
